// File: rtl/xpb_pkg.sv
// Shared constants, state encoding and parameter checks for the
// xpb reduction sequencer and its table bank.
package xpb_pkg;

    localparam int DEF_WORD_W  = 1024;
    localparam int DEF_DIGIT_W = 5;
    localparam int DEF_NUM_SEG = 8;
    localparam int DEF_GUARD   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    // Accumulator must hold low word plus NUM_SEG full-width multiples.
    function automatic bit guard_ok(input int num_seg, input int guard);
        return guard >= $clog2(num_seg + 1);
    endfunction

endpackage

// File: rtl/xpb_reduce_sequencer.sv
// Folds the high digits of a squaring result back into the residue sum by
// walking the xpb tables one segment per cycle and accumulating the results.
module xpb_reduce_sequencer
    import xpb_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int DIGIT_W = DEF_DIGIT_W,
    parameter int NUM_SEG = DEF_NUM_SEG,
    parameter int GUARD   = DEF_GUARD,
    parameter int SEG_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_W-1:0]          in_low,
    input  logic [NUM_SEG*DIGIT_W-1:0] in_high,
    output logic [SEG_W-1:0]           xpb_seg,
    output logic [DIGIT_W-1:0]         xpb_data_in,
    input  logic [WORD_W-1:0]          xpb_data_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W+GUARD-1:0]    out_sum,
    output logic                       busy
);

    if (!guard_ok(NUM_SEG, GUARD)) begin : g_guard_err
        $error("xpb_reduce_sequencer: GUARD too small for NUM_SEG");
    end

    state_t                     state;
    state_t                     state_n;
    logic [SEG_W-1:0]           cnt;
    logic [NUM_SEG*DIGIT_W-1:0] digits;
    logic [WORD_W+GUARD-1:0]    acc;
    logic                       issued;
    logic                       accept;

    assign accept  = (state == S_IDLE) && in_valid;
    assign out_sum = acc;
    assign busy    = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Operand capture, segment counter and accumulation of table results,
    // which arrive one cycle after each issued lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            digits <= '0;
            acc    <= '0;
            issued <= 1'b0;
        end else begin
            issued <= (state == S_ISSUE);
            if (accept) begin
                digits <= in_high;
                acc    <= {{GUARD{1'b0}}, in_low};
                cnt    <= '0;
            end else begin
                if (state == S_ISSUE) cnt <= cnt + 1'b1;
                if (issued) acc <= acc + {{GUARD{1'b0}}, xpb_data_out};
            end
        end
    end

    // Next state and handshake/table outputs; table address is zero
    // outside ISSUE so the bank returns zero.
    always_comb begin
        state_n     = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        xpb_seg     = '0;
        xpb_data_in = '0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = S_ISSUE;
            end
            S_ISSUE: begin
                xpb_seg     = cnt;
                xpb_data_in = digits[cnt*DIGIT_W +: DIGIT_W];
                if (cnt == SEG_W'(NUM_SEG - 1)) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                state_n = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_xpb_reduce_sequencer.sv
// Directed bench for xpb_reduce_sequencer with a registered table model
// returning digit * 2^(16*seg), or all-ones for nonzero digits in max mode.
module tb_xpb_reduce_sequencer;

    localparam int WW = 1024;
    localparam int SW = 1028;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] in_low = '0;
    logic [39:0]   in_high = '0;
    logic [2:0]    xpb_seg;
    logic [4:0]    xpb_data_in;
    logic [WW-1:0] xpb_data_out = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_sum;
    logic          busy;

    logic max_mode = 1'b0;
    int   checks = 0;
    int   errors = 0;

    xpb_reduce_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_low       (in_low),
        .in_high      (in_high),
        .xpb_seg      (xpb_seg),
        .xpb_data_in  (xpb_data_in),
        .xpb_data_out (xpb_data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] tbl(input logic [2:0] s,
                                          input logic [4:0] d);
        logic [WW-1:0] r;
        if (max_mode) r = (d != 0) ? {WW{1'b1}} : '0;
        else          r = WW'(d) << (16 * int'(s));
        return r;
    endfunction

    always @(posedge clk) xpb_data_out <= tbl(xpb_seg, xpb_data_in);

    task automatic do_accept(input logic [WW-1:0] lo, input logic [39:0] hi);
        int n = 0;
        in_low   = lo;
        in_high  = hi;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_low   = '0;
        in_high  = '0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags rdy/vld/busy=%b want 100",
                     {in_ready, out_valid, busy});
        end
        checks++;
        if (out_sum !== '0 || xpb_data_in !== 5'd0 || xpb_seg !== 3'd0) begin
            errors++;
            $display("FAIL reset_data sum=%h din=%h seg=%h want 0",
                     out_sum[127:0], xpb_data_in, xpb_seg);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_digits();
        do_accept(WW'(32'h1234), 40'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (xpb_seg !== 3'(k) || busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_seq cyc=%0d seg=%0d busy=%b vld=%b want seg=%0d",
                         k + 1, xpb_seg, busy, out_valid, k);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || xpb_seg !== 3'd0) begin
            errors++;
            $display("FAIL zero_drain vld=%b seg=%0d want 0 0", out_valid, xpb_seg);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_latency out_valid=%b want 1 at T+10", out_valid);
        end
        checks++;
        if (out_sum !== SW'(32'h1234)) begin
            errors++;
            $display("FAIL zero_sum got %h want 1234", out_sum[127:0]);
        end
        release_out();
    endtask

    task automatic test_ones();
        int lat;
        logic [SW-1:0] exp;
        exp = SW'(128'h0001_0001_0001_0001_0001_0001_0001_0011);
        do_accept(WW'(32'h10), {8{5'd1}});
        wait_out(lat);
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL ones_latency got %0d want 10", lat);
        end
        checks++;
        if (out_sum !== exp) begin
            errors++;
            $display("FAIL ones_sum got %h want %h", out_sum[127:0], exp[127:0]);
        end
        release_out();
    endtask

    task automatic test_mixed();
        int lat;
        logic [SW-1:0] exp;
        logic [39:0] hi;
        exp = SW'(128'h0008_0007_0006_0005_0004_0003_0002_0001);
        hi = {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
        do_accept('0, hi);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (xpb_data_in !== 5'(k + 1)) begin
                errors++;
                $display("FAIL mixed_addr seg=%0d din=%0d want %0d",
                         k, xpb_data_in, k + 1);
            end
            @(posedge clk); #1;
        end
        wait_out(lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL mixed_latency tail=%0d want 2", lat);
        end
        checks++;
        if (out_sum !== exp) begin
            errors++;
            $display("FAIL mixed_sum got %h want %h", out_sum[127:0], exp[127:0]);
        end
        release_out();
    endtask

    task automatic test_max();
        int lat;
        logic [SW-1:0] exp;
        exp = {4'h8, {1020{1'b1}}, 4'h7};
        max_mode = 1'b1;
        do_accept({WW{1'b1}}, {40{1'b1}});
        wait_out(lat);
        checks++;
        if (out_sum !== exp) begin
            errors++;
            $display("FAIL max_sum top=%h low=%h want top=8 low=%h",
                     out_sum[SW-1:WW], out_sum[63:0], exp[63:0]);
        end
        release_out();
        max_mode = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        do_accept(WW'(32'hABC), 40'd0);
        wait_out(lat);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_low   = WW'(32'h777);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_sum !== SW'(32'hABC)) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d vld=%b rdy=%b sum=%h want 1 0 abc",
                         k, out_valid, in_ready, out_sum[63:0]);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_low   = '0;
        release_out();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release vld=%b rdy=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int lat;
        do_accept(WW'(32'h99), {8{5'd3}});
        @(negedge clk);
        while (xpb_seg !== 3'd3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (xpb_seg !== 3'd3) begin
            errors++;
            $display("FAIL mid_reach seg=%0d want 3", xpb_seg);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
                out_sum !== '0) begin
                errors++;
                $display("FAIL mid_idle cyc=%0d vld=%b busy=%b rdy=%b sum=%h",
                         k, out_valid, busy, in_ready, out_sum[63:0]);
            end
            @(posedge clk); #1;
        end
        do_accept(WW'(32'd5), 40'd0);
        wait_out(lat);
        checks++;
        if (lat != 10 || out_sum !== SW'(32'd5)) begin
            errors++;
            $display("FAIL mid_after lat=%0d sum=%h want 10 5", lat, out_sum[63:0]);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat;
        do_accept(WW'(32'h1), {8{5'd2}});
        wait_out(lat);
        release_out();
        do_accept(WW'(32'h2), 40'd0);
        wait_out(lat);
        checks++;
        if (lat != 10 || out_sum !== SW'(32'h2)) begin
            errors++;
            $display("FAIL b2b lat=%0d sum=%h want 10 2", lat, out_sum[63:0]);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_zero_digits();
        test_ones();
        test_mixed();
        test_max();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
